// File: rtl/mul_approx_pkg.sv
// rtl/mul_approx_pkg.sv - shared mode type, defaults and truncation helpers
// for the approximate multiplier pipeline.
package mul_approx_pkg;

   typedef enum logic {
      MODE_EXACT  = 1'b0,
      MODE_APPROX = 1'b1
   } mode_e;

   localparam int WIDTH_DEFAULT = 8;
   localparam int PROD_W        = 2 * WIDTH_DEFAULT;

   // 1 when partial product a[i] & b[j] survives dropping the k lowest columns
   function automatic logic trunc_mask(input int k, input int i, input int j);
      return (i + j) >= k;
   endfunction

   // Midpoint of the dropped range, restores the expected value of the lost columns
   function automatic logic [63:0] comp_term(input int k);
      return (k > 0) ? (64'd1 << (k - 1)) : 64'd0;
   endfunction

endpackage

// File: rtl/mul_csa_row.sv
// rtl/mul_csa_row.sv - one carry-save 3:2 compressor row; the carry comes out
// already weighted (shifted left by one), with the top carry dropped.
module mul_csa_row #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   assign sum = x ^ y ^ z;

   // Products never reach 2^W, so the carry out of the top column is always zero
   assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

// File: rtl/mul_approx_pipe.sv
// rtl/mul_approx_pipe.sv - pipelined unsigned multiplier with run-time
// exact/approximate mode, valid/ready on both sides and an approximate-beat counter.
module mul_approx_pipe
   import mul_approx_pkg::*;
#(
   parameter  int WIDTH     = PROD_W / 2,
   parameter  int STAGES    = 3,
   parameter  int TRUNC_MAX = 6,
   localparam int KW        = (TRUNC_MAX > 0) ? $clog2(TRUNC_MAX + 1) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic               in_mode,
   input  logic [KW-1:0]      in_k,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               out_mode,
   output logic [31:0]        approx_cnt
);

   localparam int PW    = 2 * WIDTH;
   localparam int NL    = WIDTH - 2;
   localparam int NMID  = (STAGES >= 3) ? STAGES - 2 : 0;
   localparam int NDIV  = (NMID > 0) ? NMID : 1;
   localparam logic [KW-1:0] KMAX = KW'(TRUNC_MAX);

   typedef logic [WIDTH-1:0][PW-1:0] rows_t;

   typedef struct packed {
      logic          v;
      mode_e         mode;
      logic [KW-1:0] k;
      rows_t         rows;
   } stage_t;

   // Register positions along the reduction chain: after PP generation, then
   // at even splits of the CSA levels; the output register is always present.
   function automatic logic is_cut(input int p);
      logic hit;
      hit = 1'b0;
      if (STAGES > 1 && p == 0) hit = 1'b1;
      for (int m = 1; m <= NMID; m++) begin
         if (p == (m * NL) / NDIV) hit = 1'b1;
      end
      return hit;
   endfunction

   logic          en;
   logic [KW-1:0] k_in;
   stage_t        head;
   stage_t        pos_val   [NL+1];
   stage_t        after_reg [NL+1];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      k_in = '0;
      if (mode_e'(in_mode) == MODE_APPROX) begin
         k_in = (in_k > KMAX) ? KMAX : in_k;
      end
      head      = '0;
      head.v    = in_valid;
      head.mode = mode_e'(in_mode);
      head.k    = k_in;
      for (int j = 0; j < WIDTH; j++) begin
         for (int i = 0; i < WIDTH; i++) begin
            head.rows[j][i+j] = in_a[i] & in_b[j] & trunc_mask(int'(k_in), i, j);
         end
      end
   end

   assign pos_val[0] = head;

   // Linear carry-save chain: each level folds rows 0..2 into sum/carry and
   // shifts the remaining rows down, so rows 0/1 hold the result at the end.
   for (genvar l = 0; l < NL; l++) begin : g_lvl
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      stage_t        nxt;

      mul_csa_row #(.W(PW)) u_row (
         .x     (after_reg[l].rows[0]),
         .y     (after_reg[l].rows[1]),
         .z     (after_reg[l].rows[2]),
         .sum   (s),
         .carry (c)
      );

      always_comb begin
         nxt         = after_reg[l];
         nxt.rows[0] = s;
         nxt.rows[1] = c;
         for (int r = 2; r < WIDTH - 1; r++) begin
            nxt.rows[r] = after_reg[l].rows[r+1];
         end
         nxt.rows[WIDTH-1] = '0;
      end

      assign pos_val[l+1] = nxt;
   end

   for (genvar p = 0; p <= NL; p++) begin : g_pos
      if (is_cut(p)) begin : g_cut
         stage_t q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               q <= '0;
            end else if (en) begin
               q <= pos_val[p];
            end
         end
         assign after_reg[p] = q;
      end else begin : g_wire
         assign after_reg[p] = pos_val[p];
      end
   end

   stage_t        fin;
   logic [PW-1:0] cpa;
   logic [PW:0]   comp;
   logic [PW:0]   total;
   logic [PW-1:0] p_next;
   logic          unused_rows;

   assign fin         = after_reg[NL];
   assign cpa         = fin.rows[0] + fin.rows[1];
   assign comp        = (PW+1)'(comp_term(int'(fin.k)));
   assign total       = {1'b0, cpa} + comp;
   assign p_next      = total[PW] ? '1 : total[PW-1:0];
   assign unused_rows = ^fin.rows[WIDTH-1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_mode  <= 1'b0;
      end else if (en) begin
         out_valid <= fin.v;
         out_p     <= p_next;
         out_mode  <= (fin.mode == MODE_APPROX);
      end
   end

   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (out_valid && out_ready && out_mode) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_mul_approx_pipe.sv
// tb/tb_mul_approx_pipe.sv - randomized self-checking bench for mul_approx_pipe
// against a column-arithmetic reference model.
module tb_mul_approx_pipe;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       mode;
      logic [2:0] k;
   } beat_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_mode;
   logic [2:0]  in_k;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_p;
   logic        out_mode;
   logic [31:0] approx_cnt;

   int total = 0;
   int bad   = 0;

   beat_t       acc_q[$];
   logic [16:0] obs_q[$];

   mul_approx_pipe #(.WIDTH(8), .STAGES(3), .TRUNC_MAX(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_mode    (in_mode),
      .in_k       (in_k),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_mode   (out_mode),
      .approx_cnt (approx_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // {mode, product}: full product minus every dropped diagonal, plus half an LSB of the cut
   function automatic logic [16:0] model(input beat_t t);
      int unsigned kk;
      int unsigned drop;
      int unsigned res;
      kk = 0;
      if (t.mode) kk = (t.k > 3'd6) ? 6 : int'(t.k);
      drop = 0;
      for (int s = 0; s < int'(kk); s++) begin
         for (int i = 0; i <= s; i++) begin
            if (i < 8 && (s - i) < 8 && t.a[i] && t.b[s-i]) drop += (1 << s);
         end
      end
      res = 32'(t.a) * 32'(t.b) - drop;
      if (kk > 0) res += (1 << (kk - 1));
      if (res > 65535) res = 65535;
      return {t.mode, res[15:0]};
   endfunction

   function automatic beat_t rand_beat();
      beat_t t;
      t.a    = 8'($urandom_range(0, 255));
      t.b    = 8'($urandom_range(0, 255));
      t.mode = 1'($urandom_range(0, 1));
      t.k    = 3'($urandom_range(0, 7));
      return t;
   endfunction

   task automatic drive(input beat_t t);
      in_valid = 1'b1;
      in_a     = t.a;
      in_b     = t.b;
      in_mode  = t.mode;
      in_k     = t.k;
   endtask

   // Advance one clock, logging the transfers that happen on its edge
   task automatic cycle();
      beat_t t;
      #1;
      if (in_valid && in_ready) begin
         t.a = in_a; t.b = in_b; t.mode = in_mode; t.k = in_k;
         acc_q.push_back(t);
      end
      if (out_valid && out_ready) obs_q.push_back({out_mode, out_p});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 40 && obs_q.size() < acc_q.size(); n++) cycle();
      cycle();
   endtask

   task automatic test_reset();
      #1;
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_p !== 16'd0)      begin bad++; $display("FAIL reset_out_p got=%0d want=0", out_p); end
      total++; if (out_mode !== 1'b0)    begin bad++; $display("FAIL reset_out_mode got=%0b want=0", out_mode); end
      total++; if (approx_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", approx_cnt); end
      total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_exact_latency();
      int          lat;
      logic [16:0] seen;
      lat  = 0;
      seen = '0;
      out_ready = 1'b1;
      drive('{a: 8'hFF, b: 8'hFF, mode: 1'b0, k: 3'd0});
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (out_valid === 1'b1 && lat == 0) begin
            lat  = n;
            seen = {out_mode, out_p};
         end
         @(posedge clk);
         @(negedge clk);
      end
      total++; if (lat != 3)                 begin bad++; $display("FAIL latency got=%0d want=3", lat); end
      total++; if (seen[15:0] !== 16'd65025) begin bad++; $display("FAIL exact_255 got=%0d want=65025", seen[15:0]); end
      total++; if (seen[16] !== 1'b0)        begin bad++; $display("FAIL exact_mode got=%0b want=0", seen[16]); end
   endtask

   task automatic test_approx();
      out_ready = 1'b1;
      drive('{a: 8'h0F, b: 8'h0F, mode: 1'b1, k: 3'd4}); cycle();
      drive('{a: 8'h0F, b: 8'h0F, mode: 1'b1, k: 3'd0}); cycle();
      drain();
      total++; if (obs_q.size() != 2) begin bad++; $display("FAIL approx_count got=%0d want=2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         total++; if (obs_q[0] !== {1'b1, 16'd184}) begin bad++; $display("FAIL approx_k4 got=%0h want=%0h", obs_q[0], {1'b1, 16'd184}); end
         total++; if (obs_q[1] !== {1'b1, 16'd225}) begin bad++; $display("FAIL approx_k0 got=%0h want=%0h", obs_q[1], {1'b1, 16'd225}); end
      end
      acc_q.delete(); obs_q.delete();
   endtask

   task automatic test_clamp();
      out_ready = 1'b1;
      drive('{a: 8'hFF, b: 8'hFF, mode: 1'b1, k: 3'd7}); cycle();
      drive('{a: 8'hFF, b: 8'hFF, mode: 1'b1, k: 3'd6}); cycle();
      drain();
      total++; if (obs_q.size() != 2) begin bad++; $display("FAIL clamp_count got=%0d want=2", obs_q.size()); end
      if (obs_q.size() == 2) begin
         total++; if (obs_q[0] !== {1'b1, 16'd64736}) begin bad++; $display("FAIL clamp_k7 got=%0h want=%0h", obs_q[0], {1'b1, 16'd64736}); end
         total++; if (obs_q[1] !== {1'b1, 16'd64736}) begin bad++; $display("FAIL clamp_k6 got=%0h want=%0h", obs_q[1], {1'b1, 16'd64736}); end
      end
      acc_q.delete(); obs_q.delete();
   endtask

   task automatic test_backpressure();
      beat_t cur;
      int    sent;
      int    n;
      sent = 0;
      cur  = rand_beat();
      for (int cyc = 0; cyc < 60 && sent < 10; cyc++) begin
         drive(cur);
         out_ready = !(cyc >= 5 && cyc < 10);
         #1;
         if (!out_ready && out_valid) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
            if (obs_q.size() < acc_q.size()) begin
               total++;
               if ({out_mode, out_p} !== model(acc_q[obs_q.size()])) begin
                  bad++; $display("FAIL bp_stable got=%0h want=%0h", {out_mode, out_p}, model(acc_q[obs_q.size()]));
               end
            end
         end
         n = acc_q.size();
         cycle();
         if (acc_q.size() > n) begin
            sent++;
            cur = rand_beat();
         end
      end
      drain();
      total++; if (obs_q.size() != 10) begin bad++; $display("FAIL bp_count got=%0d want=10", obs_q.size()); end
      for (int i = 0; i < acc_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== model(acc_q[i])) begin bad++; $display("FAIL bp_beat%0d got=%0h want=%0h", i, obs_q[i], model(acc_q[i])); end
      end
      acc_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400 && acc_q.size() < 80; cyc++) begin
         drive(rand_beat());
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      drain();
      total++; if (obs_q.size() != acc_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), acc_q.size()); end
      for (int i = 0; i < acc_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== model(acc_q[i])) begin bad++; $display("FAIL rand_beat%0d got=%0h want=%0h", i, obs_q[i], model(acc_q[i])); end
      end
      acc_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive('{a: 8'(8'h31 + i), b: 8'h5A, mode: 1'b1, k: 3'd3});
         cycle();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++; if (acc_q.size() != 3)    begin bad++; $display("FAIL rst_inflight got=%0d want=3", acc_q.size()); end
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
      total++; if (approx_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", approx_cnt); end
      @(negedge clk);
      rst = 1'b0;
      acc_q.delete(); obs_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rst_emitted got=%0d want=0", obs_q.size()); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
      obs_q.delete();
   endtask

   task automatic test_counter();
      logic [6:0] pattern;
      int         n_approx;
      beat_t      t;
      pattern  = 7'b1001101;
      n_approx = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         t      = rand_beat();
         t.mode = pattern[i];
         if (pattern[i]) n_approx++;
         drive(t);
         cycle();
      end
      drain();
      total++; if (obs_q.size() != 7) begin bad++; $display("FAIL cnt_count got=%0d want=7", obs_q.size()); end
      for (int i = 0; i < acc_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== model(acc_q[i])) begin bad++; $display("FAIL cnt_beat%0d got=%0h want=%0h", i, obs_q[i], model(acc_q[i])); end
      end
      total++; if (approx_cnt !== 32'(n_approx)) begin bad++; $display("FAIL cnt_value got=%0d want=%0d", approx_cnt, n_approx); end
      acc_q.delete(); obs_q.delete();

      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      @(negedge clk);
      drive('{a: 8'h12, b: 8'h34, mode: 1'b1, k: 3'd2});
      cycle();
      drain();
      total++; if (obs_q.size() != 1)    begin bad++; $display("FAIL wrap_count got=%0d want=1", obs_q.size()); end
      total++; if (approx_cnt !== 32'd0) begin bad++; $display("FAIL wrap_value got=%0h want=0", approx_cnt); end
      acc_q.delete(); obs_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = 1'b0;
      in_k      = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_exact_latency();
      test_approx();
      test_clamp();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_counter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
